// File: rtl/wb_write_queue.sv
// Write-back queue in front of the 16x32 register file: buffers load/ALU writes in order,
// drains one per cycle onto the RF write port and forwards pending data to two operand queries.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [3:0]               ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [3:0]               alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     rf_we,
  output logic [3:0]               rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [3:0]               qa,
  input  logic [3:0]               qb,
  output logic                     hita,
  output logic                     hitb,
  output logic [DATA_W-1:0]        fwda,
  output logic [DATA_W-1:0]        fwdb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]        addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [AW-1:0]     head_r;
  logic [AW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic              full_r;
  logic              empty_r;
  logic              rf_we_r;
  logic [3:0]        rf_addr_r;
  logic [DATA_W-1:0] rf_data_r;

  logic [CW-1:0]     free_s;
  logic              ld_ready_s;
  logic              alu_ready_s;
  logic              ld_acc_s;
  logic              alu_acc_s;
  logic              pop_s;
  logic [AW-1:0]     alu_idx_s;
  logic [CW-1:0]     count_nx_s;
  logic              hita_s;
  logic              hitb_s;
  logic [DATA_W-1:0] fwda_s;
  logic [DATA_W-1:0] fwdb_s;

  // Admission control from the registered occupancy only; a same-cycle pop never frees a slot.
  always_comb begin
    free_s      = CW'(DEPTH) - count_r;
    ld_ready_s  = 1'b0;
    alu_ready_s = 1'b0;
    if (rst_n) begin
      ld_ready_s  = (free_s >= CW'(1));
      alu_ready_s = (free_s >= CW'(2)) || ((free_s == CW'(1)) && !ld_valid);
    end else begin
      ld_ready_s  = 1'b0;
      alu_ready_s = 1'b0;
    end
    ld_acc_s   = ld_valid && ld_ready_s;
    alu_acc_s  = alu_valid && alu_ready_s;
    pop_s      = rst_n && (count_r != CW'(0));
    alu_idx_s  = tail_r + AW'(ld_acc_s);
    count_nx_s = count_r + CW'(ld_acc_s) + CW'(alu_acc_s) - CW'(pop_s);
  end

  // Forwarding: RF stage is the oldest candidate, then queue entries head..tail-1 so the youngest wins.
  always_comb begin
    hita_s = 1'b0;
    hitb_s = 1'b0;
    fwda_s = '0;
    fwdb_s = '0;
    if (rf_we_r && (rf_addr_r == qa)) begin
      hita_s = 1'b1;
      fwda_s = rf_data_r;
    end else begin
      hita_s = 1'b0;
    end
    if (rf_we_r && (rf_addr_r == qb)) begin
      hitb_s = 1'b1;
      fwdb_s = rf_data_r;
    end else begin
      hitb_s = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] idx;
      logic          live;
      idx  = head_r + AW'(i);
      live = (CW'(i) < count_r);
      if (live && (addr_mem_r[idx] == qa)) begin
        hita_s = 1'b1;
        fwda_s = data_mem_r[idx];
      end else begin
        hita_s = hita_s;
      end
      if (live && (addr_mem_r[idx] == qb)) begin
        hitb_s = 1'b1;
        fwdb_s = data_mem_r[idx];
      end else begin
        hitb_s = hitb_s;
      end
    end
    if (!rst_n) begin
      hita_s = 1'b0;
      hitb_s = 1'b0;
      fwda_s = '0;
      fwdb_s = '0;
    end else begin
      hita_s = hita_s;
    end
  end

  // Entry storage; the load is the older instruction and takes the tail slot.
  always_ff @(posedge clk) begin
    if (ld_acc_s) begin
      addr_mem_r[tail_r] <= ld_addr;
      data_mem_r[tail_r] <= ld_data;
    end
    if (alu_acc_s) begin
      addr_mem_r[alu_idx_s] <= alu_addr;
      data_mem_r[alu_idx_s] <= alu_data;
    end
  end

  // Pointers, occupancy and the registered RF write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      rf_we_r   <= 1'b0;
      rf_addr_r <= 4'd0;
      rf_data_r <= '0;
    end else begin
      tail_r  <= tail_r + AW'(ld_acc_s) + AW'(alu_acc_s);
      count_r <= count_nx_s;
      full_r  <= (count_nx_s == CW'(DEPTH));
      empty_r <= (count_nx_s == CW'(0));
      if (pop_s) begin
        rf_we_r   <= 1'b1;
        rf_addr_r <= addr_mem_r[head_r];
        rf_data_r <= data_mem_r[head_r];
        head_r    <= head_r + AW'(1);
      end else begin
        rf_we_r   <= 1'b0;
      end
    end
  end

  assign ld_ready  = ld_ready_s;
  assign alu_ready = alu_ready_s;
  assign hita      = hita_s;
  assign hitb      = hitb_s;
  assign fwda      = fwda_s;
  assign fwdb      = fwdb_s;
  assign rf_we     = rf_we_r;
  assign rf_addr   = rf_addr_r;
  assign rf_data   = rf_data_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

  wb_write_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready_s),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready_s),
    .count     (count_r),
    .full      (full_r),
    .empty     (empty_r)
  );

endmodule

// Occupancy and admission invariants of the write-back queue.
module wb_write_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   ld_valid,
  input logic                   ld_ready,
  input logic                   alu_valid,
  input logic                   alu_ready,
  input logic [$clog2(DEPTH):0] count,
  input logic                   full,
  input logic                   empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

  a_full_flag : assert property (@(posedge clk) disable iff (!rst_n)
    full == (count == CW'(DEPTH)));

  a_empty_flag : assert property (@(posedge clk) disable iff (!rst_n)
    empty == (count == CW'(0)));

  a_ld_room : assert property (@(posedge clk) disable iff (!rst_n)
    ld_ready |-> (count < CW'(DEPTH)));

  a_dual_room : assert property (@(posedge clk) disable iff (!rst_n)
    (ld_valid && ld_ready && alu_valid && alu_ready) |-> (count + CW'(2) <= CW'(DEPTH)));

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized and directed bench for wb_write_queue with a queue-based reference model
// and a scoreboard that checks every register file write in order.
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]        a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0, alu_valid = 1'b0;
  logic              ld_ready, alu_ready;
  logic [3:0]        ld_addr = 4'd0, alu_addr = 4'd0, qa = 4'd0, qb = 4'd0;
  logic [DATA_W-1:0] ld_data = '0, alu_data = '0;
  logic              rf_we, hita, hitb, full, empty;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_data, fwda, fwdb;
  logic [CW-1:0]     count;

  ent_t pend[$];
  ent_t expq[$];
  ent_t rf_m = '0;
  logic rfv_m = 1'b0;
  bit   state_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .qa(qa), .qb(qb), .hita(hita), .hitb(hitb), .fwda(fwda), .fwdb(fwdb),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending write wins; the entry in the RF stage is the oldest candidate.
  task automatic fwd_model(input logic [3:0] q, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (rfv_m && rf_m.a == q) begin
      h = 1'b1;
      d = rf_m.d;
    end
    foreach (pend[i]) begin
      if (pend[i].a == q) begin
        h = 1'b1;
        d = pend[i].d;
      end
    end
  endtask

  task automatic step(input logic rn, input logic lv, input logic [3:0] la, input logic [DATA_W-1:0] ldd,
                      input logic av, input logic [3:0] aa, input logic [DATA_W-1:0] add,
                      input logic [3:0] a, input logic [3:0] b);
    logic lr_m, ar_m, h;
    logic [DATA_W-1:0] d;
    int free;
    ent_t e;
    @(negedge clk);
    if (state_ok) begin
      chk("rf_we", rf_we, rfv_m);
      chk("rf_addr", rf_addr, rf_m.a);
      chk("rf_data", rf_data, rf_m.d);
      chk("count", count, pend.size());
      chk("full", full, pend.size() == DEPTH);
      chk("empty", empty, pend.size() == 0);
    end
    rst_n = rn; ld_valid = lv; ld_addr = la; ld_data = ldd;
    alu_valid = av; alu_addr = aa; alu_data = add; qa = a; qb = b;
    #1;
    free = DEPTH - pend.size();
    lr_m = rn && (free >= 1);
    ar_m = rn && ((free >= 2) || (free == 1 && !lv));
    if (state_ok || !rn) begin
      chk("ld_ready", ld_ready, lr_m);
      chk("alu_ready", alu_ready, ar_m);
    end
    if (state_ok) begin
      if (rn) fwd_model(a, h, d); else begin h = 1'b0; d = '0; end
      chk("hita", hita, h);
      chk("fwda", fwda, d);
      if (rn) fwd_model(b, h, d); else begin h = 1'b0; d = '0; end
      chk("hitb", hitb, h);
      chk("fwdb", fwdb, d);
    end
    @(posedge clk);
    if (!rn) begin
      pend.delete();
      expq.delete();
      rfv_m = 1'b0;
      rf_m = '0;
      state_ok = 1'b1;
    end else begin
      if (pend.size() > 0) begin
        rf_m = pend.pop_front();
        rfv_m = 1'b1;
      end else begin
        rfv_m = 1'b0;
      end
      if (lv && lr_m) begin
        e.a = la; e.d = ldd;
        pend.push_back(e); expq.push_back(e);
      end
      if (av && ar_m) begin
        e.a = aa; e.d = add;
        pend.push_back(e); expq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, a, b);
  endtask

  // Scoreboard monitor: every RF write must be the oldest accepted, not-yet-written request.
  always @(negedge clk) begin
    ent_t e;
    if (state_ok && rst_n === 1'b1 && rf_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rf_unexpected: write addr %0h data %0h with nothing pending", rf_addr, rf_data);
      end else begin
        e = expq.pop_front();
        chk("sb_addr", rf_addr, e.a);
        chk("sb_data", rf_data, e.d);
      end
    end
  end

  initial begin
    step(1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 4'd0, 4'd0);

    // single ALU write R3 = 0xAA, observed through latency and forwarding
    step(1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd3, 32'h0000_00AA, 4'd3, 4'd3);
    idle(4, 4'd3, 4'd0);

    // dual-source stream across pointer wrap
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 4'd1, 32'h1100_0000 + 32'(i), 1'b1, 4'd2, 32'h2200_0000 + 32'(i), 4'd1, 4'd2);
    idle(6, 4'd1, 4'd2);

    // same-register pair in one cycle: ALU value is younger
    step(1'b1, 1'b1, 4'd5, 32'h5, 1'b1, 4'd5, 32'h7, 4'd5, 4'd5);
    idle(4, 4'd5, 4'd5);

    // R9 visible only in the RF output stage, then gone
    step(1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd9, 32'h99, 4'd0, 4'd9);
    idle(4, 4'd0, 4'd9);

    // fill, then ALU-only, then both again to exercise the free==1 rule
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'd6, 32'h600 + 32'(i), 1'b1, 4'd7, 32'h700 + 32'(i), 4'd6, 4'd7);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd8, 32'h800 + 32'(i), 4'd8, 4'd7);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'd10, 32'hA00 + 32'(i), 1'b1, 4'd11, 32'hB00 + 32'(i), 4'd10, 4'd11);

    // reset with entries queued
    idle(1, 4'd10, 4'd11);
    step(1'b0, 1'b1, 4'd10, 32'hDEAD, 1'b1, 4'd11, 32'hBEEF, 4'd10, 4'd11);
    idle(4, 4'd10, 4'd11);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom(),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom(),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    idle(DEPTH + 4, 4'd0, 4'd0);
    chk("drain_empty", expq.size(), 0);
    chk("final_count", count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
